// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_t      : sequencer states IDLE / FETCH / DRAIN / DONE
//   DEF_ADDR_W   : default instruction memory address width
//   DEF_INSTR_W  : default instruction width ({opcode[2:0], imm[7:0]})
//   OPC_MSB/LSB  : opcode field position inside an instruction word
//   make_instr   : packs an opcode and an immediate into one instruction word
package instr_fetch_pkg;

  localparam int unsigned DEF_ADDR_W  = 6;
  localparam int unsigned DEF_INSTR_W = 11;

  localparam int unsigned OPC_MSB = 10;
  localparam int unsigned OPC_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [DEF_INSTR_W-1:0] make_instr(input logic [2:0] opc,
                                                       input logic [7:0] imm);
    logic [DEF_INSTR_W-1:0] w;
    w                  = '0;
    w[OPC_MSB:OPC_LSB] = opc;
    w[OPC_LSB-1:0]     = imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_fifo2.sv
// fetch_fifo2: two-entry prefetch FIFO between instruction memory and decoder.
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active-low
//   push   in   write wdata this cycle
//   pop    in   consume head this cycle
//   wdata  in   WIDTH-bit word to store
//   count  out  number of stored words (0..2)
//   head   out  oldest stored word (0 after reset)
// Push and pop together are accepted at every occupancy, including full.
module fetch_fifo2
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != 2'd0);
  // a full FIFO can still take a word when the head leaves in the same cycle
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = rd_ptr ? slot1 : slot0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0  <= '0;
      slot1  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) slot1 <= wdata;
        else        slot0 <= wdata;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetch sequencer in front of the decoder/ALU datapath.
// Drives the instruction memory address/rw lines, loads programs while idle,
// and streams fetched words to execute through a 2-entry prefetch FIFO.
//   clk, rst              clock; asynchronous active-low reset
//   start, start_addr     begin fetching at start_addr (IDLE only)
//   halt                  stop issuing reads, drain, then finish (FETCH only)
//   load_en/addr/data     program-load write (IDLE only, beats start)
//   mem_rw/addr/wdata     memory controls (1 = read), combinational
//   mem_rdata             memory read data, valid one cycle after the address
//   instr_out/valid/ready FIFO head handshake to the decoder
//   pc_out                next address to be issued
//   busy                  sequencer not idle
//   done                  one-cycle pulse at the end of a run
// Build option: FETCH_LOOP_EN -- an issue at LAST_ADDR wraps pc to 0 and keeps
// fetching; only halt ends the run.
module instr_fetch_seq
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned INSTR_W   = DEF_INSTR_W,
  parameter int unsigned LAST_ADDR = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               halt,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               mem_rw,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LAST_PC = LAST_ADDR[ADDR_W-1:0];

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [1:0]        count;
  logic              pop;
  logic              issue;
  logic              at_last;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign at_last     = (pc == LAST_PC);
  assign pc_out      = pc;

  // Credit check: stored words plus the read in flight, less the word leaving
  // now, must stay below the FIFO depth so a returning read always has a slot.
  assign issue = (state == FETCH) && !halt &&
                 (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    mem_rw    = 1'b1;
    mem_addr  = pc;
    mem_wdata = '0;
    if ((state == IDLE) && load_en) begin
      mem_rw    = 1'b0;
      mem_addr  = load_addr;
      mem_wdata = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !load_en) begin
            pc    <= start_addr;
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (halt) begin
            state <= DRAIN;
          end else if (issue) begin
`ifdef FETCH_LOOP_EN
            if (at_last) pc <= '0;
            else         pc <= pc + ADDR_W'(1);
`else
            pc <= pc + ADDR_W'(1);
            if (at_last) state <= DRAIN;
`endif
          end
        end
        DRAIN: begin
          // inflight==0 also means no push is due this cycle
          if ((count == 2'd0) && !inflight) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo2 #(
    .WIDTH(INSTR_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .wdata(mem_rdata),
    .count(count),
    .head (instr_out)
  );

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Testbench for instr_fetch_seq: memory model, reference program image,
// scoreboard queue of expected instruction words and an independent monitor.
module tb_instr_fetch_seq;
  import instr_fetch_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned IW = 11;
`ifdef FETCH_LOOP_EN
  localparam int unsigned LAST = 1;
`else
  localparam int unsigned LAST = 7;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          halt;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          done;

  instr_fetch_seq #(
    .ADDR_W(AW),
    .INSTR_W(IW),
    .LAST_ADDR(LAST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .halt(halt),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_out(pc_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: registered read, write when rw=0
  logic [IW-1:0] mem [64];
  always @(posedge clk) begin
    if (!mem_rw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  logic [IW-1:0] ref_mem [64];
  logic [IW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            delivered = 0;
  int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'($urandom_range(0, 1));
      default: instr_ready = 1'b0;
    endcase
  end

  // monitor: compares every accepted word with the scoreboard head
  logic          prev_stall = 1'b0;
  logic [IW-1:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && instr_valid) check("hold_stable", instr_out, prev_word);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", instr_out, $time);
        end else begin
          check("word", instr_out, exp_q.pop_front());
          delivered++;
        end
      end
      prev_stall = instr_valid && !instr_ready;
      prev_word  = instr_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    tick();
    load_en    = 1'b1;
    load_addr  = a;
    load_data  = d;
    start      = 1'($urandom_range(0, 1));   // must lose to load_en
    start_addr = AW'($urandom_range(0, LAST));
    @(negedge clk);
    check("load_rw", mem_rw, 0);
    check("load_addr", mem_addr, a);
    check("load_wdata", mem_wdata, d);
    ref_mem[a] = d;
  endtask

  task automatic end_load();
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    check("load_keeps_idle", busy, 0);
  endtask

  // expected stream: consecutive addresses, wrapping after LAST
  task automatic start_run(input logic [AW-1:0] s, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_q.push_back(ref_mem[(int'(s) + i) % (LAST + 1)]);
    delivered = 0;
    tick();
    start      = 1'b1;
    start_addr = s;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("issue_addr", mem_addr, s);
    check("issue_rw", mem_rw, 1);
    check("busy_run", busy, 1);
    check("valid_t1", instr_valid, 0);
    @(negedge clk);
    check("valid_t2", instr_valid, 0);
    @(negedge clk);
    check("valid_t3", instr_valid, 1);
  endtask

  task automatic wait_done(input bit halted);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check("busy_in_done", busy, 1);
      end
    end
    check("done_seen", seen, 1);
    if (!halted) check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
    exp_q.delete();
  endtask

  task automatic halt_finish();
    logic [AW-1:0] pc_ref;
    bit            seen = 1'b0;
    tick();
    halt = 1'b1;
    @(negedge clk);
    pc_ref = pc_out;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else      check("pc_frozen", pc_out, pc_ref);
    end
    check("halt_done_seen", seen, 1);
    @(negedge clk);
    check("halt_idle_after", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] s;
    logic [AW-1:0] pc_ref;
    logic [IW-1:0] w_ref;
    rst = 1'b0; start = 1'b0; start_addr = '0; halt = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc", pc_out, 0);
    check("rst_rw", mem_rw, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    #2 rst = 1'b1;

    load_word(0, make_instr(3'd0, 8'h92));
    load_word(1, make_instr(3'd1, 8'h9A));
    load_word(2, make_instr(3'd2, 8'hD2));
    load_word(3, make_instr(3'd3, 8'h92));
    for (int a = 4; a <= LAST; a++) load_word(AW'(a), IW'($urandom));
    end_load();

`ifndef FETCH_LOOP_EN
    // readback of the loaded program, consumer always ready
    rdy_mode = 0;
    start_run(0, LAST + 1);
    wait_done(0);

    for (int r = 0; r < 8; r++) begin
      s = AW'($urandom_range(0, LAST));
      rdy_mode = $urandom_range(0, 1);
      start_run(s, LAST - int'(s) + 1);
      if (r % 2 == 1) begin
        // start/load outside IDLE must be ignored
        tick();
        start = 1'b1; start_addr = AW'($urandom_range(0, LAST));
        load_en = 1'b1; load_addr = AW'($urandom_range(0, LAST)); load_data = IW'($urandom);
        @(negedge clk);
        check("ignored_load_rw", mem_rw, 1);
        tick();
        start = 1'b0; load_en = 1'b0;
      end
      wait_done(0);
      if (r % 3 == 0) begin
        load_word(AW'($urandom_range(0, LAST)), IW'($urandom));
        end_load();
      end
    end

    // backpressure: five cycles without ready mid-run
    rdy_mode = 0;
    start_run(0, LAST + 1);
    rdy_mode = 2;
    @(negedge clk);
    pc_ref = pc_out;
    w_ref  = instr_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", instr_valid, 1);
      check("bp_no_issue", pc_out, pc_ref);
      check("bp_instr", instr_out, w_ref);
    end
    rdy_mode = 1;
    wait_done(0);

    // halt during the cycle the second word is taken
    rdy_mode = 0;
    start_run(0, LAST + 1);
    halt_finish();
    check("halt_word_count", (delivered >= 2) && (delivered <= 4), 1);
    exp_q.delete();
`else
    // looping program: w0,w1,w0,w1... with no done until halt
    rdy_mode = 0;
    start_run(0, 60);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("loop_no_done", done, 0);
    end
    halt_finish();
    check("loop_word_count", delivered >= 20, 1);
    exp_q.delete();
`endif

    // asynchronous reset with a full FIFO
    rdy_mode = 2;
    start_run(0, LAST + 1);
    @(negedge clk);
    check("pre_rst_valid", instr_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc_out, 0);
    check("arst_busy", busy, 0);
    check("arst_instr", instr_out, 0);
    check("arst_rw", mem_rw, 1);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", instr_valid, 0);

`ifndef FETCH_LOOP_EN
    s = AW'($urandom_range(0, LAST));
    start_run(s, LAST - int'(s) + 1);
    wait_done(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
